// File: rtl/seq_mult8.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// armed by holding reset low, result flagged by rdy after WIDTH edges.
module seq_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               rdy
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      ctr;
  logic               running;
  logic               cur_bit;
  logic [2*WIDTH-1:0] pp;

  // Operands track a/b only while reset is low; the last edge before release wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand <= {{WIDTH{1'b0}}, a};
      mplr  <= b;
    end
  end

  always_comb begin
    running = (ctr < CW'(WIDTH));
    cur_bit = mplr[0];
    pp      = '0;
    if (running) begin
      cur_bit = mplr[ctr[$clog2(WIDTH)-1:0]];
      pp      = mcand << ctr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p   <= '0;
      rdy <= 1'b0;
      ctr <= '0;
    end else if (running) begin
      if (cur_bit) p <= p + pp;
      ctr <= ctr + 1'b1;
      if (ctr == CW'(WIDTH - 1)) rdy <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_mult8.sv
// Randomized scoreboard bench for seq_mult8: stimulus pushes a*b on release,
// a negedge monitor pops and checks product and 8-edge latency on rdy rise.
module tb_seq_mult8;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] p;
  logic        rdy;

  typedef struct { logic [15:0] prod; int rel; } exp_t;
  exp_t sb[$];

  int passed = 0, total = 0, done_cnt = 0, cyc = 0;
  logic        rdy_q = 1'b0;
  logic [15:0] hold_p = '0;

  seq_mult8 #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .a(a), .b(b), .p(p), .rdy(rdy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: rising rdy consumes one expectation; steady rdy must hold p.
  always @(negedge clk) begin
    if (reset && rdy && !rdy_q) begin
      if (sb.size() == 0) chk("unexpected_rdy", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", 32'(p), 32'(e.prod));
        chk("latency", 32'(cyc - e.rel), 32'd8);
      end
      done_cnt++;
    end else if (reset && rdy && rdy_q) begin
      chk("hold_p", 32'(p), 32'(hold_p));
    end
    hold_p = p;
    rdy_q  = reset ? rdy : 1'b0;
  end

  // Hold reset low for n edges with operands x/y, then release and predict.
  task automatic start(input logic [7:0] x, input logic [7:0] y, input int n);
    exp_t e;
    reset = 1'b0; a = x; b = y;
    #1;
    chk("reset_p", 32'(p), 32'd0);
    chk("reset_rdy", 32'(rdy), 32'd0);
    repeat (n) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    e.prod = 16'(int'(x) * int'(y));
    e.rel  = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int d0;
    bit got;
    d0 = done_cnt; got = 0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) got = 1;
    end
    if (!got) begin
      chk("rdy_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("por_p", 32'(p), 32'd0);
    chk("por_rdy", 32'(rdy), 32'd0);

    // Basic product, then 20 cycles of hold checked by the monitor.
    start(8'd5, 8'd7, 2);
    wait_done();
    repeat (20) @(negedge clk);
    #1 chk("basic_hold", 32'(p), 32'd35);

    start(8'd255, 8'd255, 1); wait_done();
    start(8'd0,   8'd200, 1); wait_done();
    start(8'd1,   8'd200, 1); wait_done();
    start(8'd128, 8'd2,   1); wait_done();

    // Operand change while running is ignored.
    start(8'd12, 8'd10, 1);
    repeat (3) @(posedge clk);
    #1 a = 8'd99; b = 8'd99;
    wait_done();

    // Abort mid-run with an asynchronous reset between clock edges.
    start(8'd9, 8'd9, 1);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_p", 32'(p), 32'd0);
    chk("abort_rdy", 32'(rdy), 32'd0);
    void'(sb.pop_back());
    start(8'd3, 8'd4, 1);
    wait_done();

    // Release and re-assert with no edge in between: state stays clear.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; #1 reset = 1'b0; #1;
    chk("glitch_p", 32'(p), 32'd0);
    chk("glitch_rdy", 32'(rdy), 32'd0);

    for (int i = 0; i < 500; i++) begin
      start(8'($urandom), 8'($urandom), 1 + int'($urandom_range(0, 1)));
      wait_done();
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
